lcd_ctrl: RTL
=============

Name: lcd_ctrl

Overview:
- Peripheral-side consumer of the CPU's LCD output register; drives an HD44780-compatible character LCD in 8-bit mode.
- Stores to the LCD address arrive as single-cycle write strobes and are queued in a small FIFO.
- The block runs the power-up init sequence, then replays each queued byte with correct RS/EN setup, pulse and execution timing.
- A status word returns to the CPU read path so software can poll busy/overflow instead of bit-banging EN.

Parameters:
FIFO_DEPTH, 4, queued writes (power of two, >=2)
CNT_W, 20, width of the shared timing counter
T_POWERUP, 750000, cycles from reset release to first init command (15 ms @ 50 MHz)
T_SETUP, 2, cycles RS/data are stable before EN rises
T_EN_HIGH, 12, cycles EN is held high
T_CMD, 2000, execution wait after EN falls, normal command/data (40 us)
T_CLEAR, 82000, execution wait after EN falls for RS=0 bytes 0x01/0x02 (1.64 ms)

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_wr_en  in  1  one-cycle strobe: store hit the LCD register
i_wr_data  in  32  store data: [31] backlight, [30] clear-overflow command, [8] RS, [7:0] byte
o_status  out  32  [0] busy, [1] init_done, [2] overflow, [5:3] FIFO count, others 0
o_lcd_data  out  8  LCD DB7..DB0
o_lcd_rs  out  1  register select
o_lcd_rw  out  1  read/write, constant 0
o_lcd_en  out  1  enable strobe
o_lcd_on  out  1  LCD power
o_lcd_blon  out  1  backlight

Behaviour:
- Reset (i_reset=0, async): FIFO emptied, FSM=PWRUP, counter=0, seq index=0.
- Reset values: o_lcd_data=0, rs=0, rw=0, en=0, on=0, blon=0, overflow=0, init_done=0.
- o_lcd_on goes 1 on the first clock edge after reset release and stays 1.
- Reset asserted mid-transfer: EN drops immediately and the whole sequence restarts from PWRUP.
- Write handling:
  - Each i_wr_en copies [31] to o_lcd_blon at the next edge, whether the write is accepted, dropped or a clear.
  - If [30]=1: overflow is cleared and nothing is enqueued.
  - Otherwise {RS, byte} is enqueued unless the FIFO is full.
  - Full with a pop in the same cycle: the write is accepted.
  - Full with no pop: the write is dropped and overflow is set (sticky).
- Writes are accepted during PWRUP/INIT and are buffered until init completes.
- FSM states:
  - PWRUP: count T_POWERUP cycles -> INIT_LOAD.
  - INIT_LOAD: drive RS=0, data=ROM[idx]; ROM = 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 -> SETUP.
  - IDLE: if FIFO non-empty, pop and register {RS, data} onto the pins -> SETUP; else stay.
  - SETUP: T_SETUP cycles -> EN_HI.
  - EN_HI: o_lcd_en=1 for exactly T_EN_HIGH cycles -> WAIT, with EN=0.
  - WAIT: count T_CLEAR if RS=0 and data is 0x01 or 0x02, else T_CMD.
  - WAIT exit during init: idx++, then INIT_LOAD, or IDLE with init_done=1 after idx 5.
  - WAIT exit after init: IDLE.
- o_lcd_data and o_lcd_rs hold their value from load through the end of WAIT; they are never changed while EN=1.
- Latency: a write at edge k into an empty FIFO with the FSM in IDLE puts pins valid after edge k+1, raises EN after edge k+1+T_SETUP, and drops EN after edge k+1+T_SETUP+T_EN_HIGH.
- Back-to-back queued bytes: the next pop happens on the IDLE cycle immediately after WAIT ends. One idle cycle between transfers is required.
- busy = (state != IDLE) || FIFO non-empty. All o_status fields are registered-state derived, with no combinational path from i_wr_en.
- Counter: loaded with 0 on state entry, compared against the parameter minus 1, and saturates. Parameters must fit in CNT_W.

Test Plan:
All scenarios use T_POWERUP=100, T_SETUP=2, T_EN_HIGH=4, T_CMD=20, T_CLEAR=50, FIFO_DEPTH=4.
1. Release reset, no writes -> after 100 cycles, 6 EN pulses (each 4 cycles) with data 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 and RS=0. The 0x01 pulse is followed by a 50-cycle wait, the others by 20. init_done=1, busy=0 afterwards.
2. After init, write 0x0000_0141 -> pins RS=1, data=0x41 one edge later; EN high 2 cycles later for 4 cycles; busy returns to 0 after the 20-cycle wait plus 1.
3. After init, write 0x8000_0001 -> blon=1 next edge; RS=0, data=0x01 pulse followed by a 50-cycle wait.
4. During WAIT, write 6 bytes in consecutive cycles -> first 4 are queued, last 2 dropped; overflow=1, count=4. Write 0x4000_0000 -> overflow=0, count still 4. All 4 bytes emerge in order.
5. With a full FIFO, write in the exact cycle IDLE pops -> write accepted, overflow stays 0, count stays 4.
6. Assert reset while EN=1 -> EN=0 immediately, FIFO count=0, init_done=0. After release, the power-up sequence of scenario 1 repeats.

Source files
------------

// File: rtl/lcd_ctrl_if.sv
// CPU-side bus of the LCD controller: one-cycle store strobe and data
// towards the peripheral, polled status word back to the CPU read path.
interface lcd_ctrl_if;
    logic        i_wr_en;
    logic [31:0] i_wr_data;
    logic [31:0] o_status;

    // CPU (store side) drives the strobe and data, reads status
    modport master (
        output i_wr_en,
        output i_wr_data,
        input  o_status
    );

    // The LCD controller consumes stores and publishes status
    modport slave (
        input  i_wr_en,
        input  i_wr_data,
        output o_status
    );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780 character LCD controller, 8-bit mode.
// CPU stores are queued in a small FIFO; the FSM runs the power-up init
// sequence and then replays each queued {RS, byte} with setup, EN pulse and
// execution wait timing. A status word lets software poll busy/overflow.
module lcd_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned T_POWERUP  = 750000,
    parameter int unsigned T_SETUP    = 2,
    parameter int unsigned T_EN_HIGH  = 12,
    parameter int unsigned T_CMD      = 2000,
    parameter int unsigned T_CLEAR    = 82000
) (
    input  logic         i_clk,
    input  logic         i_reset,
    lcd_ctrl_if.slave    bus,
    output logic [7:0]   o_lcd_data,
    output logic         o_lcd_rs,
    output logic         o_lcd_rw,
    output logic         o_lcd_en,
    output logic         o_lcd_on,
    output logic         o_lcd_blon
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    // Counter terminal values: the counter starts at 0 on state entry, so a
    // phase of N cycles ends when the counter reads N-1.
    localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(T_POWERUP - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] ENHI_LAST  = CNT_W'(T_EN_HIGH - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(T_CLEAR - 1);
    localparam logic [CW-1:0]    FIFO_FULL  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_PWRUP     = 3'd0,
        ST_INIT_LOAD = 3'd1,
        ST_IDLE      = 3'd2,
        ST_SETUP     = 3'd3,
        ST_EN_HI     = 3'd4,
        ST_WAIT      = 3'd5
    } state_t;

    // Power-up init command list (function set x3, display on, clear, entry mode)
    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        logic [7:0] val;
        case (idx)
            3'd0, 3'd1, 3'd2: val = 8'h38;
            3'd3:             val = 8'h0C;
            3'd4:             val = 8'h01;
            3'd5:             val = 8'h06;
            default:          val = 8'h00;
        endcase
        return val;
    endfunction

    // ------------------------------------------------------------------
    // Write FIFO
    // ------------------------------------------------------------------
    logic [8:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          blon_q;
    logic          on_q;

    state_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]     idx_q, idx_d;
    logic           init_done_q, init_done_d;
    logic           en_q, en_d;
    logic [7:0]     data_q, data_d;
    logic           rs_q, rs_d;

    logic           fifo_empty;
    logic           fifo_full;
    logic           pop;
    logic           wr_clear;
    logic           wr_data_req;
    logic           push;
    logic           drop;
    logic [CNT_W-1:0] wait_last;
    logic           busy;
    logic [2:0]     status_count;
    logic           unused_wr_bits;

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == FIFO_FULL);
    // IDLE pops whenever something is queued; that frees a slot this cycle
    assign pop         = (state_q == ST_IDLE) && !fifo_empty;
    assign wr_clear    = bus.i_wr_en && bus.i_wr_data[30];
    assign wr_data_req = bus.i_wr_en && !bus.i_wr_data[30];
    assign push        = wr_data_req && (!fifo_full || pop);
    assign drop        = wr_data_req && fifo_full && !pop;

    // Queue bookkeeping: pointers wrap naturally, count tracks occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
        if (wr_clear) begin
            ovf_d = 1'b0;
        end else if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // FIFO storage: plain write port, no reset needed on the data array
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {bus.i_wr_data[8], bus.i_wr_data[7:0]};
        end
    end

    // FIFO state, sticky overflow, backlight and LCD power registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            blon_q   <= 1'b0;
            on_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            on_q     <= 1'b1;
            if (bus.i_wr_en) begin
                blon_q <= bus.i_wr_data[31];
            end
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    // Clear/home (RS=0, 0x01 or 0x02) need the long execution wait
    assign wait_last = (!rs_q && (data_q == 8'h01 || data_q == 8'h02)) ? CLEAR_LAST : CMD_LAST;

    // Next state, pin loads and shared counter
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        en_d        = en_q;
        data_d      = data_q;
        rs_d        = rs_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_PWRUP: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = ST_INIT_LOAD;
                end
            end
            ST_INIT_LOAD: begin
                rs_d    = 1'b0;
                data_d  = init_rom(idx_q);
                state_d = ST_SETUP;
            end
            ST_IDLE: begin
                if (!fifo_empty) begin
                    {rs_d, data_d} = fifo_mem[rd_ptr_q];
                    state_d        = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    en_d    = 1'b1;
                    state_d = ST_EN_HI;
                end
            end
            ST_EN_HI: begin
                if (cnt_q == ENHI_LAST) begin
                    en_d    = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == wait_last) begin
                    if (!init_done_q) begin
                        if (idx_q == 3'd5) begin
                            init_done_d = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            state_d = ST_INIT_LOAD;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                en_d    = 1'b0;
                state_d = ST_PWRUP;
            end
        endcase
        // Counter restarts on every state change and saturates otherwise
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // FSM state, counter, init progress and LCD pin registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_PWRUP;
            cnt_q       <= '0;
            idx_q       <= '0;
            init_done_q <= 1'b0;
            en_q        <= 1'b0;
            data_q      <= '0;
            rs_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            en_q        <= en_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all derived from registers, nothing combinational from i_wr_en
    // ------------------------------------------------------------------
    assign busy           = (state_q != ST_IDLE) || !fifo_empty;
    assign status_count   = 3'(count_q);
    assign bus.o_status   = {26'd0, status_count, ovf_q, init_done_q, busy};
    assign unused_wr_bits = ^bus.i_wr_data[29:9];

    assign o_lcd_data = data_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = en_q;
    assign o_lcd_on   = on_q;
    assign o_lcd_blon = blon_q;

endmodule
